stage_wb_arb: RTL
=================

Name: stage_wb_arb

Overview:
- Parametrised multi-channel writeback stage. Accepts completed results from NCH independent execution channels (e.g. ALU, load, mul/div), each through its own small FIFO.
- Round-robin arbitrates one architectural register write per cycle and drives the regfile write port plus the EXE forwarding bus.
- Successor to the single-channel writeback stage; adds buffering, backpressure, arbitration and flush.

Parameters:
- NCH, 3, number of input channels (2..8)
- DEPTH, 2, entries per channel FIFO (power of two, >=2)
- XLEN, 64, result width

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous active-high reset
- wb_flush  input  1  discard all buffered and same-cycle-offered entries
- in_valid  input  NCH  channel c offers an entry
- in_ready  output  NCH  channel c FIFO can accept
- in_rd  input  NCH*5  destination register, channel c at [5c+4:5c]
- in_rd_en  input  NCH  entry writes a register
- in_mem_read  input  NCH  select readdata instead of result
- in_result  input  NCH*XLEN  computed result
- in_readdata  input  NCH*XLEN  load data
- wb_ready  output  1  AND of in_ready
- wb_rd  output  5  write-port register index
- wb_rd_en  output  1  write-port enable
- wb_result  output  XLEN  write-port data
- wb_fw_valid  output  1  forwarding valid (== wb_rd_en)
- wb_fw_rd  output  5  forwarding register (== wb_rd)
- wb_fw_result  output  XLEN  forwarding data (== wb_result)
- wb_conflict_cnt  output  32  arbitration-conflict counter (see Optional Feature)

Behaviour:
- Push: at a clk edge where in_valid[c] and in_ready[c] are both high and wb_flush is low, push {rd, rd_en, data} into FIFO c.
  - data = in_mem_read[c] ? in_readdata[c] : in_result[c]. The select is made at push time; XLEN bits are stored.
- in_ready[c] = (count[c] != DEPTH), from registered state only. No lookahead: a full FIFO with a same-cycle pop still shows ready=0.
- Heads: a channel's head is valid when count[c] != 0.
- Arbitration: combinational, round-robin.
  - Search starts at channel rr_ptr and wraps modulo NCH; the first valid head is granted.
  - At most one grant per cycle. The granted head pops at the edge.
  - On grant to channel g, rr_ptr <= (g+1) mod NCH. With no grant, rr_ptr holds.
- Write outputs: combinational from the granted head.
  - wb_rd_en = grant_valid & head.rd_en & (head.rd != 0).
  - wb_rd and wb_result come from the granted head. When no grant: wb_rd = 0, wb_result = 0, wb_rd_en = 0.
  - Entries with rd_en = 0 or rd = 0 are still granted and popped, but produce no write.
- Latency: an entry pushed at edge N can appear on wb_* in cycle N+1 (registered FIFO, combinational read) at the earliest.
- Forwarding outputs are identical copies of the write outputs in the same cycle.
- Per-channel order is FIFO. No ordering is guaranteed across channels; the issue logic prevents WAW hazards between channels.
- Pointers wrap modulo DEPTH. count has log2(DEPTH)+1 bits.
- Simultaneous push and pop on one non-full FIFO: count is unchanged, both pointers advance.
- wb_flush (synchronous, sampled at the edge):
  - All counts and pointers go to 0; same-cycle pushes are dropped.
  - The pop that cycle is dropped, and wb_rd_en is forced to 0 during the flush cycle.
  - rr_ptr resets to 0.
- Reset (async): all counts, pointers and rr_ptr go to 0.
  - in_ready = all ones; wb_ready = 1.
  - wb_rd_en = 0, wb_rd = 0, wb_result = 0, wb_conflict_cnt = 0.
  - FIFO data storage is not reset.
- Mid-operation reset: all buffered entries are lost; no write is produced in the reset cycle.

Optional Feature:
- Macro STAGE_WB_CONFLICT_CNT_EN.
- When defined: wb_conflict_cnt increments by 1 each non-flush cycle in which two or more heads are valid.
  - Saturates at 32'hFFFF_FFFF.
  - Clears on rst and on wb_flush.
- When undefined: wb_conflict_cnt is tied to 0 and no counter flops exist.

Test Plan:
- Reset, then single push on ch1 (rd=5, rd_en=1, mem_read=0, result=64'h1234) -> next cycle wb_rd_en=1, wb_rd=5, wb_result=64'h1234, wb_fw_* identical; following cycle wb_rd_en=0.
- Same-edge pushes on ch0 (rd=1), ch1 (rd=2), ch2 (rd=3) with rr_ptr=0 -> writes of rd 1, 2, 3 in three consecutive cycles; rr_ptr ends at 0; with CONFLICT_CNT_EN, wb_conflict_cnt=2.
- Push 3 entries on ch0 with DEPTH=2 while ch2 holds an older pending head -> in_ready[0]=0 after 2 accepts; third accepted only after a ch0 pop; ch0 write order preserved.
- Push with rd=0, rd_en=1, and with rd=7, rd_en=0 -> entry consumed (count decrements) but wb_rd_en=0 both cycles.
- Load on ch1 (mem_read=1, readdata=64'hDEAD, result=64'hBEEF) -> wb_result=64'hDEAD.
- Fill ch0 and ch2, assert wb_flush for one cycle with a new push offered -> flush cycle wb_rd_en=0; all in_ready=1 next cycle; no writes ever appear for the dropped entries; counter reads 0.

Source files
------------

// File: rtl/stage_wb_arb_if.sv
// Bus bundle between the execution channels and the writeback stage.
// The slave modport is the writeback stage's view; master is the producer/consumer side.
interface stage_wb_arb_if #(
  parameter int NCH  = 3,
  parameter int XLEN = 64
);
  logic                wb_flush;
  logic [NCH-1:0]      in_valid;
  logic [NCH-1:0]      in_ready;
  logic [NCH*5-1:0]    in_rd;
  logic [NCH-1:0]      in_rd_en;
  logic [NCH-1:0]      in_mem_read;
  logic [NCH*XLEN-1:0] in_result;
  logic [NCH*XLEN-1:0] in_readdata;
  logic                wb_ready;
  logic [4:0]          wb_rd;
  logic                wb_rd_en;
  logic [XLEN-1:0]     wb_result;
  logic                wb_fw_valid;
  logic [4:0]          wb_fw_rd;
  logic [XLEN-1:0]     wb_fw_result;
  logic [31:0]         wb_conflict_cnt;

  modport slave (
    input  wb_flush, in_valid, in_rd, in_rd_en, in_mem_read, in_result, in_readdata,
    output in_ready, wb_ready, wb_rd, wb_rd_en, wb_result,
           wb_fw_valid, wb_fw_rd, wb_fw_result, wb_conflict_cnt
  );

  modport master (
    output wb_flush, in_valid, in_rd, in_rd_en, in_mem_read, in_result, in_readdata,
    input  in_ready, wb_ready, wb_rd, wb_rd_en, wb_result,
           wb_fw_valid, wb_fw_rd, wb_fw_result, wb_conflict_cnt
  );
endinterface

// File: rtl/stage_wb_arb.sv
// Multi-channel writeback stage: per-channel FIFOs, round-robin pick of one register write per cycle.
// Optional arbitration-conflict counter enabled by defining STAGE_WB_CONFLICT_CNT_EN.
module stage_wb_arb #(
  parameter int NCH   = 3,
  parameter int DEPTH = 2,
  parameter int XLEN  = 64
) (
  input  logic          clk,
  input  logic          rst,
  stage_wb_arb_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int PW = $clog2(NCH);

  typedef struct packed {
    logic [4:0]      rd;
    logic            rd_en;
    logic [XLEN-1:0] data;
  } entry_t;

  entry_t        mem_q      [NCH][DEPTH];
  logic [AW-1:0] wr_ptr_q   [NCH];
  logic [AW-1:0] wr_ptr_d   [NCH];
  logic [AW-1:0] rd_ptr_q   [NCH];
  logic [AW-1:0] rd_ptr_d   [NCH];
  logic [CW-1:0] count_q    [NCH];
  logic [CW-1:0] count_d    [NCH];
  entry_t        in_entry   [NCH];
  entry_t        head_entry [NCH];

  logic [PW-1:0]  rr_ptr_q, rr_ptr_d;
  logic [NCH-1:0] ready, head_valid, push, pop;

  logic           hi_found, lo_found;
  logic [PW-1:0]  hi_idx, lo_idx;
  logic           grant_valid;
  logic [PW-1:0]  grant_idx;
  entry_t         grant_entry;
  logic           write_en;

  // Channel-side view: readiness and head validity come only from registered counts.
  always_comb begin
    for (int c = 0; c < NCH; c++) begin
      ready[c]          = (count_q[c] != CW'(DEPTH));
      head_valid[c]     = (count_q[c] != '0);
      push[c]           = bus.in_valid[c] & ready[c] & ~bus.wb_flush;
      in_entry[c].rd    = bus.in_rd[5*c +: 5];
      in_entry[c].rd_en = bus.in_rd_en[c];
      in_entry[c].data  = bus.in_mem_read[c] ? bus.in_readdata[XLEN*c +: XLEN]
                                             : bus.in_result[XLEN*c +: XLEN];
      head_entry[c]     = mem_q[c][rd_ptr_q[c]];
    end
  end

  // Round-robin: the lowest valid index at or above rr_ptr wins, else the lowest valid overall.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (no latch).
    hi_found    = 1'b0;
    lo_found    = 1'b0;
    hi_idx      = '0;
    lo_idx      = '0;
    grant_entry = '0;
    for (int c = NCH - 1; c >= 0; c--) begin
      if (head_valid[c]) begin
        lo_found = 1'b1;
        lo_idx   = PW'(c);
        if (PW'(c) >= rr_ptr_q) begin
          hi_found = 1'b1;
          hi_idx   = PW'(c);
        end
      end
    end
    grant_valid = lo_found;
    grant_idx   = hi_found ? hi_idx : lo_idx;
    for (int c = 0; c < NCH; c++) begin
      if (grant_valid && (grant_idx == PW'(c))) grant_entry = head_entry[c];
    end
  end

  always_comb begin
    for (int c = 0; c < NCH; c++) begin
      pop[c]      = grant_valid & (grant_idx == PW'(c)) & ~bus.wb_flush;
      wr_ptr_d[c] = wr_ptr_q[c];
      rd_ptr_d[c] = rd_ptr_q[c];
      count_d[c]  = count_q[c];
      if (bus.wb_flush) begin
        wr_ptr_d[c] = '0;
        rd_ptr_d[c] = '0;
        count_d[c]  = '0;
      end else begin
        if (push[c]) wr_ptr_d[c] = wr_ptr_q[c] + 1'b1;
        if (pop[c])  rd_ptr_d[c] = rd_ptr_q[c] + 1'b1;
        unique case ({push[c], pop[c]})
          2'b10:   count_d[c] = count_q[c] + 1'b1;
          2'b01:   count_d[c] = count_q[c] - 1'b1;
          default: count_d[c] = count_q[c];
        endcase
      end
    end

    rr_ptr_d = rr_ptr_q;
    if (bus.wb_flush) begin
      rr_ptr_d = '0;
    end else if (grant_valid) begin
      rr_ptr_d = (grant_idx == PW'(NCH - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      for (int c = 0; c < NCH; c++) begin
        wr_ptr_q[c] <= '0;
        rd_ptr_q[c] <= '0;
        count_q[c]  <= '0;
      end
      rr_ptr_q <= '0;
    end else begin
      for (int c = 0; c < NCH; c++) begin
        wr_ptr_q[c] <= wr_ptr_d[c];
        rd_ptr_q[c] <= rd_ptr_d[c];
        count_q[c]  <= count_d[c];
      end
      rr_ptr_q <= rr_ptr_d;
    end
  end

  // NOTE: entry storage has no reset; count_q alone defines which slots hold live data.
  always_ff @(posedge clk) begin
    for (int c = 0; c < NCH; c++) begin
      if (push[c]) mem_q[c][wr_ptr_q[c]] <= in_entry[c];
    end
  end

  // Register x0 and rd_en=0 entries drain through the arbiter without producing a write.
  assign write_en = grant_valid & grant_entry.rd_en & (grant_entry.rd != 5'd0) & ~bus.wb_flush;

  assign bus.in_ready     = ready;
  assign bus.wb_ready     = &ready;
  assign bus.wb_rd_en     = write_en;
  assign bus.wb_rd        = grant_entry.rd;
  assign bus.wb_result    = grant_entry.data;
  assign bus.wb_fw_valid  = write_en;
  assign bus.wb_fw_rd     = grant_entry.rd;
  assign bus.wb_fw_result = grant_entry.data;

`ifdef STAGE_WB_CONFLICT_CNT_EN
  logic [31:0] conflict_cnt_q, conflict_cnt_d;
  logic        multi_head;

  // More than one bit set in head_valid means some channel lost arbitration this cycle.
  assign multi_head = (head_valid & (head_valid - 1'b1)) != '0;

  always_comb begin
    conflict_cnt_d = conflict_cnt_q;
    if (bus.wb_flush) begin
      conflict_cnt_d = '0;
    end else if (multi_head && (conflict_cnt_q != 32'hFFFF_FFFF)) begin
      conflict_cnt_d = conflict_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) conflict_cnt_q <= '0;
    else     conflict_cnt_q <= conflict_cnt_d;
  end

  assign bus.wb_conflict_cnt = conflict_cnt_q;
`else
  assign bus.wb_conflict_cnt = '0;
`endif

  for (genvar c = 0; c < NCH; c++) begin : g_chk
    a_count_bound : assert property (@(posedge clk) disable iff (rst) count_q[c] <= CW'(DEPTH));
  end

endmodule
